npcg_toggle_bnc_ca_seq: RTL and testbench
=========================================

# npcg_toggle_bnc_ca_seq

Parametrised successor to the single-command BNC issuer in the Toggle NAND path controller generator. It accepts one command from the dispatcher, then drives the primitive-manager (PM) CAL engine with a variable-length sequence: one command byte followed by 0–5 address bytes. It then issues a programmable post-sequence timer and reports completion. It sits beside the other NPCG_Toggle_BNC_* blocks and shares the same dispatcher and PM buses.

## Interface
Parameters:
- NumberOfWays, 4, width of way-select and target-way buses
- TimerCycles, 3, value driven on oPM_NumOfData during the timer phase (16-bit)

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  reset; synchronous, active-high
- iOpcode  in  6  command opcode
- iTargetID  in  5  target ID
- iSourceID  in  5  unused
- iLength  in  16  [7:0] command byte, [10:8] address byte count A, [15] timer skip (macro only), rest ignored
- iCMDValid  in  1  command valid
- oCMDReady  out  1  ready for a command
- iWaySelect  in  NumberOfWays  target way(s)
- iColAddress  in  16  column address
- iRowAddress  in  24  row address
- oStart  out  1  command accepted this cycle
- oLastStep  out  1  sequence complete pulse
- iPM_Ready  in  8  PM engine ready flags
- iPM_LastStep  in  8  PM engine last-step flags
- oPM_PCommand  out  8  PM trigger vector
- oPM_PCommandOption  out  3  PM option
- oPM_TargetWay  out  NumberOfWays  latched way
- oPM_NumOfData  out  16  PM count
- oPM_CASelect  out  1  0 = command byte, 1 = address byte
- oPM_CAData  out  8  CA byte

## Operation
- Trigger: iCMDValid && iTargetID==5'b00101 && iOpcode==6'b010001. oStart equals the trigger (combinational). Acceptance happens only in Idle.
- On acceptance, latch iWaySelect, iLength, and address bytes B1..B5 = col[7:0], col[15:8], row[7:0], row[15:8], row[23:16].
- A is clamped: values 6 or 7 are treated as 5. Total bytes N = A+1.
- States:
  - Idle → CALIssue on trigger.
  - CALIssue: oPM_PCommand=8'b00001000, NumOfData=N-1; leave to CAWrite when iPM_Ready[6:0]==7'h7F.
  - CAWrite: one cycle per byte, index k = 0..N-1. Byte k=0 is the command byte with CASelect=0; bytes k≥1 are B_k with CASelect=1. After k==N-1 go to TMIssue.
  - TMIssue: oPM_PCommand=8'b00000001, option 3'b110, NumOfData=TimerCycles; go to WaitDone when iPM_LastStep[3].
  - WaitDone: oLastStep = iPM_LastStep[0]; on it, go to Idle.
- oCMDReady = (state==Idle). All PM command, option and count outputs are 0 outside the states listed above. oPM_CASelect and oPM_CAData are 0 outside CAWrite.
- Unknown or illegal state encodings go to Idle.
- Trigger while not Idle: ignored, no latch. oStart may still pulse; the dispatcher qualifies it with oCMDReady.

## Timing
- Reset: state Idle; latched registers 0. Outputs: oCMDReady=1; all other outputs 0, except oStart, which follows inputs.
- Reset mid-operation aborts immediately to Idle. No oLastStep is generated.
- CA data is registered from the next state, so byte k is valid in the same cycle the state is CAWrite[k]. There are no bubbles between bytes.
- Minimum latency from acceptance to oLastStep (ready and last-step flags immediate): 1 (CALIssue) + N (CAWrite) + 1 (TMIssue) + 1 (WaitDone) cycles.
- iPM_LastStep[0] is ignored outside WaitDone. iPM_LastStep[3] is ignored outside TMIssue and WaitCAL.
- The byte counter is 3 bits; it never wraps because it stops at N-1 ≤ 5.

## Configuration
- NPCG_BNC_CA_SEQ_TIMER_SKIP_EN defined: when iLength[15]==1, the last CAWrite goes to state WaitCAL (no PM trigger, all PM outputs 0). In WaitCAL, oLastStep = iPM_LastStep[3], and the block returns to Idle on it. When iLength[15]==0, behaviour is unchanged.
- Not defined: iLength[15] is ignored, WaitCAL does not exist, and the timer phase always runs.

## Test plan
- Command 0x90, A=0, ways=4'b0010, ready immediate: exactly one CAWrite cycle (CASelect=0, CAData=0x90), then PCommand=0x01 with NumOfData=3. oLastStep fires 4 cycles after acceptance (flags already high).
- Command 0x00, A=5, col=0x1234, row=0xABCDEF: CAData sequence 00,34,12,EF,CD,AB with CASelect 0,1,1,1,1,1; NumOfData=5 during CALIssue.
- A=7 clamps: exactly 6 CA bytes; iPM_Ready[6:0]=0x7E for 10 cycles holds CALIssue with PCommand=0x08.
- Second trigger during WaitDone: no latch and oCMDReady=0; after oLastStep, a new trigger in Idle is accepted.
- iReset asserted during CAWrite k=2: next cycle is Idle, all PM outputs 0, oCMDReady=1, no oLastStep.
- Macro defined, iLength[15]=1, A=2: no PCommand=0x01 ever; oLastStep coincides with iPM_LastStep[3] in WaitCAL.

Source files
------------

// File: rtl/npcg_toggle_bnc_ca_seq.sv
// BNC command/address sequencer: one command byte plus 0-5 address bytes to the PM CAL engine, then a timer.
// Optional NPCG_BNC_CA_SEQ_TIMER_SKIP_EN: iLength[15]=1 skips the timer and completes on the CAL last-step flag.
module npcg_toggle_bnc_ca_seq #(
  parameter int NumberOfWays = 4,
  parameter int TimerCycles  = 3
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [15:0]             iLength,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  input  logic [15:0]             iColAddress,
  input  logic [23:0]             iRowAddress,
  output logic                    oStart,
  output logic                    oLastStep,
  input  logic [7:0]              iPM_Ready,
  input  logic [7:0]              iPM_LastStep,
  output logic [7:0]              oPM_PCommand,
  output logic [2:0]              oPM_PCommandOption,
  output logic [NumberOfWays-1:0] oPM_TargetWay,
  output logic [15:0]             oPM_NumOfData,
  output logic                    oPM_CASelect,
  output logic [7:0]              oPM_CAData
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAL_ISSUE = 3'd1,
    S_CA_WRITE  = 3'd2,
    S_TM_ISSUE  = 3'd3,
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
    S_WAIT_DONE = 3'd4,
    S_WAIT_CAL  = 3'd5
`else
    S_WAIT_DONE = 3'd4
`endif
  } state_t;

  state_t                  state, state_nx;
  logic [2:0]              idx, idx_nx;
  logic [2:0]              last_idx;
  logic [NumberOfWays-1:0] way_r;
  logic [7:0]              cmd_r;
  logic [15:0]             col_r;
  logic [23:0]             row_r;
  logic                    ca_sel_r;
  logic [7:0]              ca_data_r, byte_nx;
  logic                    trigger;
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
  logic                    skip_r;
`endif

  logic unused_bits;
  assign unused_bits = ^{iSourceID, iLength[15:11], iPM_Ready[7], iPM_LastStep[7:4], iPM_LastStep[2:1]};

  assign trigger       = iCMDValid && (iTargetID == 5'b00101) && (iOpcode == 6'b010001);
  assign oStart        = trigger;
  assign oCMDReady     = (state == S_IDLE);
  assign oPM_TargetWay = way_r;
  assign oPM_CASelect  = ca_sel_r;
  assign oPM_CAData    = ca_data_r;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_nx           = state;
    idx_nx             = idx;
    oPM_PCommand       = 8'h00;
    oPM_PCommandOption = 3'b000;
    oPM_NumOfData      = 16'h0000;
    oLastStep          = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) state_nx = S_CAL_ISSUE;
      end
      S_CAL_ISSUE: begin
        oPM_PCommand  = 8'b0000_1000;
        oPM_NumOfData = {13'd0, last_idx};
        idx_nx        = 3'd0;
        if (iPM_Ready[6:0] == 7'h7F) state_nx = S_CA_WRITE;
      end
      S_CA_WRITE: begin
        if (idx == last_idx) begin
          idx_nx = 3'd0;
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
          state_nx = skip_r ? S_WAIT_CAL : S_TM_ISSUE;
`else
          state_nx = S_TM_ISSUE;
`endif
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      S_TM_ISSUE: begin
        oPM_PCommand       = 8'b0000_0001;
        oPM_PCommandOption = 3'b110;
        oPM_NumOfData      = 16'(TimerCycles);
        if (iPM_LastStep[3]) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        oLastStep = iPM_LastStep[0];
        if (iPM_LastStep[0]) state_nx = S_IDLE;
      end
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
      S_WAIT_CAL: begin
        oLastStep = iPM_LastStep[3];
        if (iPM_LastStep[3]) state_nx = S_IDLE;
      end
`endif
      default: begin
        state_nx = S_IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // Byte for the upcoming CAWrite index, so the registered CA outputs line up with the state.
  always_comb begin
    byte_nx = cmd_r;
    case (idx_nx)
      3'd1:    byte_nx = col_r[7:0];
      3'd2:    byte_nx = col_r[15:8];
      3'd3:    byte_nx = row_r[7:0];
      3'd4:    byte_nx = row_r[15:8];
      3'd5:    byte_nx = row_r[23:16];
      default: byte_nx = cmd_r;
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iReset) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      last_idx  <= 3'd0;
      way_r     <= '0;
      cmd_r     <= 8'h00;
      col_r     <= 16'h0000;
      row_r     <= 24'h000000;
      ca_sel_r  <= 1'b0;
      ca_data_r <= 8'h00;
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
      skip_r    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if ((state == S_IDLE) && trigger) begin
        way_r    <= iWaySelect;
        cmd_r    <= iLength[7:0];
        last_idx <= (iLength[10:8] > 3'd5) ? 3'd5 : iLength[10:8];
        col_r    <= iColAddress;
        row_r    <= iRowAddress;
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
        skip_r   <= iLength[15];
`endif
      end
      ca_sel_r  <= (state_nx == S_CA_WRITE) && (idx_nx != 3'd0);
      ca_data_r <= (state_nx == S_CA_WRITE) ? byte_nx : 8'h00;
    end
  end

endmodule

// File: tb/tb_npcg_toggle_bnc_ca_seq.sv
// Scoreboard bench for npcg_toggle_bnc_ca_seq: stimulus queues per-cycle expectations, a monitor compares busy cycles.
module tb_npcg_toggle_bnc_ca_seq;

  localparam int TIMER = 3;
`ifdef NPCG_BNC_CA_SEQ_TIMER_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        iSystemClock = 1'b0;
  logic        iReset = 1'b1;
  logic [5:0]  iOpcode = '0;
  logic [4:0]  iTargetID = '0;
  logic [4:0]  iSourceID = '0;
  logic [15:0] iLength = '0;
  logic        iCMDValid = 1'b0;
  logic        oCMDReady;
  logic [3:0]  iWaySelect = '0;
  logic [15:0] iColAddress = '0;
  logic [23:0] iRowAddress = '0;
  logic        oStart;
  logic        oLastStep;
  logic [7:0]  iPM_Ready = 8'hFF;
  logic [7:0]  iPM_LastStep = 8'hFF;
  logic [7:0]  oPM_PCommand;
  logic [2:0]  oPM_PCommandOption;
  logic [3:0]  oPM_TargetWay;
  logic [15:0] oPM_NumOfData;
  logic        oPM_CASelect;
  logic [7:0]  oPM_CAData;

  npcg_toggle_bnc_ca_seq #(.NumberOfWays(4), .TimerCycles(TIMER)) dut (
    .iSystemClock(iSystemClock), .iReset(iReset), .iOpcode(iOpcode), .iTargetID(iTargetID),
    .iSourceID(iSourceID), .iLength(iLength), .iCMDValid(iCMDValid), .oCMDReady(oCMDReady),
    .iWaySelect(iWaySelect), .iColAddress(iColAddress), .iRowAddress(iRowAddress),
    .oStart(oStart), .oLastStep(oLastStep), .iPM_Ready(iPM_Ready), .iPM_LastStep(iPM_LastStep),
    .oPM_PCommand(oPM_PCommand), .oPM_PCommandOption(oPM_PCommandOption),
    .oPM_TargetWay(oPM_TargetWay), .oPM_NumOfData(oPM_NumOfData),
    .oPM_CASelect(oPM_CASelect), .oPM_CAData(oPM_CAData)
  );

  always #5 iSystemClock = ~iSystemClock;

  typedef struct packed {
    logic [7:0]  pcmd;
    logic [2:0]  opt;
    logic [15:0] nod;
    logic        sel;
    logic [7:0]  data;
    logic        last;
    logic [3:0]  way;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic [7:0] pcmd, input logic [2:0] opt, input logic [15:0] nod,
                              input logic sel, input logic [7:0] data, input logic last, input logic [3:0] way);
    obs_t o;
    o = {pcmd, opt, nod, sel, data, last, way};
    return o;
  endfunction

  // Monitor: every cycle the block is busy it must present exactly the next queued expectation.
  obs_t act_o, exp_o;
  always @(negedge iSystemClock) begin
    if (oCMDReady === 1'b0) begin
      act_o = {oPM_PCommand, oPM_PCommandOption, oPM_NumOfData, oPM_CASelect, oPM_CAData, oLastStep, oPM_TargetWay};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_busy_cycle: got %0h expected none (t=%0t)", act_o, $time);
      end else begin
        exp_o = exp_q.pop_front();
        check("busy_cycle", 64'(act_o), 64'(exp_o));
      end
    end
  end

  task automatic run_cmd(input logic [7:0] cmd, input logic [2:0] a_raw, input logic [15:0] col,
                         input logic [23:0] row, input logic [3:0] ways, input int stall,
                         input int hold, input logic skip_bit, input int rst_k);
    logic [2:0] a;
    logic [7:0] b [6];
    int         n, wd;
    logic       do_skip;
    bit         done;
    a       = (a_raw > 3'd5) ? 3'd5 : a_raw;
    n       = int'(a) + 1;
    do_skip = skip_bit && SKIP_EN;
    b[0] = cmd;          b[1] = col[7:0];    b[2] = col[15:8];
    b[3] = row[7:0];     b[4] = row[15:8];   b[5] = row[23:16];
    for (int i = 0; i <= stall; i++) exp_q.push_back(mk(8'h08, 3'b000, {13'd0, a}, 1'b0, 8'h00, 1'b0, ways));
    for (int k = 0; k < n; k++)
      if (rst_k < 0 || k <= rst_k) exp_q.push_back(mk(8'h00, 3'b000, 16'h0, (k != 0), b[k], 1'b0, ways));
    if (rst_k < 0) begin
      if (!do_skip) exp_q.push_back(mk(8'h01, 3'b110, 16'(TIMER), 1'b0, 8'h00, 1'b0, ways));
      for (int i = 0; i < hold; i++) exp_q.push_back(mk(8'h00, 3'b000, 16'h0, 1'b0, 8'h00, 1'b0, ways));
      exp_q.push_back(mk(8'h00, 3'b000, 16'h0, 1'b0, 8'h00, 1'b1, ways));
    end
    wd = stall + 1 + n + (do_skip ? 0 : 1);
    iPM_Ready    = (stall > 0) ? 8'h7E : 8'hFF;
    iPM_LastStep = (hold > 0) ? 8'hFE : 8'hFF;

    @(posedge iSystemClock); #1;
    iCMDValid   = 1'b1;
    iOpcode     = 6'b010001;
    iTargetID   = 5'b00101;
    iLength     = {skip_bit, 4'b0000, a_raw, cmd};
    iWaySelect  = ways;
    iColAddress = col;
    iRowAddress = row;
    #1;
    check("start_on_trigger", 64'(oStart), 64'(1));
    check("ready_before_accept", 64'(oCMDReady), 64'(1));
    @(posedge iSystemClock); #1;
    iCMDValid = 1'b0;

    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c == stall) iPM_Ready = 8'hFF;
      if (hold > 0 && c == wd) begin
        iCMDValid   = 1'b1;
        iWaySelect  = 4'b1000;
        iLength     = 16'h0155;
        iColAddress = 16'hFFFF;
        #1;
        check("start_while_busy", 64'(oStart), 64'(1));
        check("ready_while_busy", 64'(oCMDReady), 64'(0));
      end
      if (hold > 0 && c == wd + 1) iCMDValid = 1'b0;
      if (c == wd + hold) iPM_LastStep = 8'hFF;
      if (rst_k >= 0 && c == stall + 1 + rst_k) iReset = 1'b1;
      @(posedge iSystemClock); #1;
      if (oCMDReady) done = 1'b1;
    end
    iCMDValid = 1'b0;
    check("return_to_idle", 64'(oCMDReady), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    if (rst_k >= 0) begin
      check("rst_abort_outputs",
            64'({oPM_PCommand, oPM_PCommandOption, oPM_NumOfData, oPM_CASelect, oPM_CAData, oPM_TargetWay}), 64'(0));
      check("rst_abort_no_laststep", 64'(oLastStep), 64'(0));
      iReset = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge iSystemClock);
    #1;
    check("reset_ready", 64'(oCMDReady), 64'(1));
    check("reset_pm_outputs",
          64'({oPM_PCommand, oPM_PCommandOption, oPM_NumOfData, oPM_CASelect, oPM_CAData, oPM_TargetWay}), 64'(0));
    check("reset_laststep", 64'(oLastStep), 64'(0));
    iReset = 1'b0;

    // Single command byte, immediate flags: CAL, one CA byte, timer, done.
    run_cmd(8'h90, 3'd0, 16'h0000, 24'h000000, 4'b0010, 0, 0, 1'b0, -1);
    // Full five-address-byte sequence.
    run_cmd(8'h00, 3'd5, 16'h1234, 24'hABCDEF, 4'b0101, 0, 0, 1'b0, -1);
    // A=7 clamps to five address bytes; PM not ready for 10 cycles.
    run_cmd(8'hA5, 3'd7, 16'h5A6B, 24'h7C8D9E, 4'b0001, 10, 0, 1'b0, -1);
    // A=6 also clamps.
    run_cmd(8'h61, 3'd6, 16'h0102, 24'h030405, 4'b0100, 0, 0, 1'b0, -1);
    // Second trigger during a held WaitDone is ignored; then a fresh command is accepted.
    run_cmd(8'h3C, 3'd2, 16'hBEEF, 24'h123456, 4'b0011, 0, 3, 1'b0, -1);
    run_cmd(8'h11, 3'd1, 16'h00C3, 24'h000000, 4'b1100, 0, 0, 1'b0, -1);

    // Wrong target ID and wrong opcode never trigger.
    @(posedge iSystemClock); #1;
    iCMDValid = 1'b1; iTargetID = 5'b00110; iOpcode = 6'b010001;
    #1 check("start_wrong_id", 64'(oStart), 64'(0));
    @(posedge iSystemClock); #1;
    check("no_accept_wrong_id", 64'(oCMDReady), 64'(1));
    iTargetID = 5'b00101; iOpcode = 6'b010000;
    #1 check("start_wrong_opcode", 64'(oStart), 64'(0));
    @(posedge iSystemClock); #1;
    check("no_accept_wrong_opcode", 64'(oCMDReady), 64'(1));
    iCMDValid = 1'b0;

    // Reset during CAWrite k=2 aborts with no completion pulse.
    run_cmd(8'h70, 3'd5, 16'h2211, 24'h554433, 4'b1010, 0, 0, 1'b0, 2);
    run_cmd(8'h22, 3'd0, 16'h0000, 24'h000000, 4'b0001, 0, 0, 1'b0, -1);

    // iLength[15]: skips the timer only when the option is built in.
    run_cmd(8'hE0, 3'd2, 16'h4321, 24'h000077, 4'b0110, 0, 0, 1'b1, -1);

    repeat (3) @(posedge iSystemClock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
